dmem_wbuf: RTL

//  Data-memory subsystem downstream of the pipelined core's MEM stage. Accepts core stores
//  in one cycle into a small posted-write FIFO and drains them to a single-port data RAM
//  in cycles without a load. Loads are served combinationally in the same cycle. Load data

---
 rtl/dmem_pkg.sv | 14 +
 rtl/wbuf_fwd_match.sv | 32 +++
 rtl/dmem_wbuf.sv | 104 ++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and default geometry for the data-memory posted-write buffer.
package dmem_pkg;

  localparam int unsigned DefDepth = 4;
  localparam int unsigned DefAw    = 10;
  localparam int unsigned DefDw    = 32;
  localparam int unsigned WB_PTR_W = $clog2(DefDepth);

  typedef struct packed {
    logic [DefAw-1:0] addr;
    logic [DefDw-1:0] data;
  } wbuf_entry_t;

endpackage

// File: rtl/wbuf_fwd_match.sv
// Age-ordered address comparator: returns data of the youngest valid entry matching daddr.
module wbuf_fwd_match
  import dmem_pkg::*;
#(
  parameter int unsigned Depth = DefDepth,
  localparam int unsigned PtrW = $clog2(Depth)
) (
  input  wbuf_entry_t      entries_i [Depth],
  input  logic [Depth-1:0] valid_i,
  input  logic [PtrW-1:0]  head_i,
  input  logic [DefAw-1:0] daddr_i,
  output logic             hit_o,
  output logic [DefDw-1:0] data_o
);

  logic [PtrW-1:0] idx;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int unsigned k = 0; k < Depth; k++) begin
      idx = head_i + PtrW'(k);
      if (valid_i[idx] && (entries_i[idx].addr == daddr_i)) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/dmem_wbuf.sv
// Posted-write buffer between the core MEM stage and a single-port data RAM, with
// store-to-load forwarding. Never stalls the core.
module dmem_wbuf
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned AW    = DefAw,
  parameter int unsigned DW    = DefDw,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic [AW-1:0]   daddr,
  input  logic [DW-1:0]   ddata_w,
  input  logic            d_rw,
  input  logic            d_rd,
  output logic [DW-1:0]   ddata_r,
  output logic [AW-1:0]   ram_addr,
  output logic [DW-1:0]   ram_wdata,
  output logic            ram_we,
  input  logic [DW-1:0]   ram_rdata,
  output logic [CntW-1:0] wb_count,
  output logic            wb_empty,
  output logic            overflow
);

  wbuf_entry_t      mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             overflow_q, overflow_d;

  logic full, drain, push;
  logic fwd_hit;
  logic [DW-1:0] fwd_data;

  // Drain is gated by reset so pending stores are discarded rather than written.
  assign full  = (count_q == CntW'(DEPTH));
  assign drain = RESET_N & (count_q != '0) & ~d_rd;
  assign push  = d_rw & (~full | drain);

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    valid_d    = valid_q;
    overflow_d = overflow_q | (d_rw & ~push);
    count_d    = count_q + CntW'(push) - CntW'(drain);
    if (drain) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    // Applied after the pop so a full-buffer push into the freed slot stays valid.
    if (push) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[tail_q] <= '{addr: daddr, data: ddata_w};
    end
  end

  wbuf_fwd_match #(
    .Depth (DEPTH)
  ) u_fwd_match (
    .entries_i (mem_q),
    .valid_i   (valid_q),
    .head_i    (head_q),
    .daddr_i   (daddr),
    .hit_o     (fwd_hit),
    .data_o    (fwd_data)
  );

  always_comb begin
    ram_we    = drain;
    ram_addr  = drain ? mem_q[head_q].addr : daddr;
    ram_wdata = mem_q[head_q].data;
    ddata_r   = (d_rd && fwd_hit) ? fwd_data : ram_rdata;
  end

  assign wb_count = count_q;
  assign wb_empty = (count_q == '0);
  assign overflow = overflow_q;

endmodule
